// File: rtl/ccf_pkg.sv
// Shared types for the count-connected core feeder: widths, FSM states and result record.
package ccf_pkg;

  localparam int GRAPH_W = 128;
  localparam int COUNT_W = 6;
  // Tag width carried in the result record; the feeder's EXTRA_DATA_WIDTH defaults to it.
  localparam int TAG_W   = 10;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    IDLE  = 2'd3
  } ccf_state_t;

  typedef struct packed {
    logic [COUNT_W-1:0] count;
    logic [TAG_W-1:0]   tag;
  } ccf_result_t;

endpackage

// File: rtl/ccf_result_fifo.sv
// Synchronous first-word-fall-through FIFO holding core results; push while full is
// accepted only when a pop frees the slot in the same cycle.
module ccf_result_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             wr_en;
  logic             rd_en;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign rd_en   = pop_i & ~empty_o;
  assign wr_en   = push_i & (~full_o | rd_en);
  assign dout_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/count_connected_core_feeder.sv
// Job scheduler in front of one pipelined count-connected core: slot-driven issue, credit-guarded
// result FIFO, stretched core reset and drain-to-idle. Optional CCF_PERF_COUNTERS_EN adds perf counters.
module count_connected_core_feeder
  import ccf_pkg::*;
#(
  parameter int EXTRA_DATA_WIDTH           = TAG_W,
  parameter int DATA_IN_LATENCY            = 4,
  parameter int STARTING_CONNECT_COUNT_LAG = 3,
  parameter int RESULT_FIFO_DEPTH          = 32,
  parameter int RST_STRETCH                = 64
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   job_valid,
  output logic                                   job_ready,
  input  logic [GRAPH_W-1:0]                     job_graph,
  input  logic [COUNT_W-1:0]                     job_start_count,
  input  logic [EXTRA_DATA_WIDTH-1:0]            job_tag,
  input  logic                                   drain,
  output logic                                   core_rst,
  input  logic                                   core_request,
  output logic [GRAPH_W-1:0]                     core_graph,
  output logic                                   core_start,
  output logic [COUNT_W-1:0]                     core_start_count,
  output logic [EXTRA_DATA_WIDTH-1:0]            core_extra,
  input  logic                                   core_done,
  input  logic [COUNT_W-1:0]                     core_count,
  input  logic [EXTRA_DATA_WIDTH-1:0]            core_tag,
  output logic                                   res_valid,
  input  logic                                   res_ready,
  output logic [COUNT_W-1:0]                     res_count,
  output logic [EXTRA_DATA_WIDTH-1:0]            res_tag,
  output logic [$clog2(RESULT_FIFO_DEPTH+1)-1:0] in_flight,
  output logic                                   idle,
  output logic [1:0]                             err
`ifdef CCF_PERF_COUNTERS_EN
  ,
  output logic [31:0]                            perf_offered,
  output logic [31:0]                            perf_used,
  output logic [31:0]                            perf_starved,
  output logic [31:0]                            perf_stalled
`endif
);

  localparam int IFW  = $clog2(RESULT_FIFO_DEPTH + 1);
  localparam int SW   = $clog2(RST_STRETCH + 1);
  localparam int LAT  = DATA_IN_LATENCY;
  localparam int PIPE = DATA_IN_LATENCY + STARTING_CONNECT_COUNT_LAG;

  ccf_state_t             state_q, state_d;
  logic                   core_rst_q;
  logic [SW-1:0]          stretch_q;
  logic                   stretch_done;
  logic [IFW-1:0]         in_flight_q, in_flight_d;
  logic [IFW-1:0]         credits_q, credits_d;
  logic [1:0]             err_q;
  logic                   accept;
  logic                   done_ok;
  logic                   push;
  logic                   pop;
  logic                   spurious;
  logic                   overflow;
  logic                   fifo_full;
  logic                   fifo_empty;
  ccf_result_t            push_data;
  ccf_result_t            pop_data;

  logic [PIPE-1:0]             vld_q;
  logic [GRAPH_W-1:0]          graph_q [LAT];
  logic [EXTRA_DATA_WIDTH-1:0] tag_q   [LAT];
  logic [COUNT_W-1:0]          scnt_q  [PIPE];

  // Control: core reset stretch and handshake decode
  assign stretch_done = core_rst_q & (stretch_q == SW'(RST_STRETCH - 1));
  assign core_rst     = core_rst_q | rst;
  assign job_ready    = (state_q == RUN) & core_request & (credits_q != '0);
  assign accept       = job_valid & job_ready;
  assign done_ok      = core_done & ~core_rst;
  assign spurious     = done_ok & (in_flight_q == '0);
  assign push         = done_ok & (in_flight_q != '0);
  assign pop          = res_valid & res_ready;
  assign overflow     = push & fifo_full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      core_rst_q <= 1'b1;
      stretch_q  <= '0;
    end else if (core_rst_q) begin
      if (stretch_done) core_rst_q <= 1'b0;
      else              stretch_q  <= stretch_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HOLD:    if (stretch_done) state_d = RUN;
      RUN:     if (drain) state_d = DRAIN;
      DRAIN: begin
        if (!drain)                                  state_d = RUN;
        else if ((in_flight_q == '0) && fifo_empty) state_d = IDLE;
      end
      IDLE:    if (!drain) state_d = RUN;
      default: state_d = HOLD;
    endcase
  end

  always_comb begin
    in_flight_d = in_flight_q;
    case ({accept, push})
      2'b10:   in_flight_d = in_flight_q + 1'b1;
      2'b01:   in_flight_d = in_flight_q - 1'b1;
      default: in_flight_d = in_flight_q;
    endcase
    credits_d = credits_q;
    case ({accept, pop})
      2'b10:   credits_d = credits_q - 1'b1;
      2'b01:   credits_d = credits_q + 1'b1;
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HOLD;
      in_flight_q <= '0;
      credits_q   <= IFW'(RESULT_FIFO_DEPTH);
      err_q       <= '0;
      vld_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_flight_q <= in_flight_d;
      credits_q   <= credits_d;
      err_q       <= err_q | {spurious, overflow};
      vld_q       <= {vld_q[PIPE-2:0], accept};
    end
  end

  // Issue stage p0..p(LAT-1) carries graph/tag; count rides on to the lagged slot
  always_ff @(posedge clk) begin
    graph_q[0] <= job_graph;
    tag_q[0]   <= job_tag;
    scnt_q[0]  <= job_start_count;
    for (int i = 1; i < LAT; i++) begin
      graph_q[i] <= graph_q[i-1];
      tag_q[i]   <= tag_q[i-1];
    end
    for (int i = 1; i < PIPE; i++) begin
      scnt_q[i] <= scnt_q[i-1];
    end
  end

  // Core-facing outputs are forced to zero outside their valid slot
  assign core_start       = vld_q[LAT-1];
  assign core_graph       = vld_q[LAT-1]  ? graph_q[LAT-1] : '0;
  assign core_extra       = vld_q[LAT-1]  ? tag_q[LAT-1]   : '0;
  assign core_start_count = vld_q[PIPE-1] ? scnt_q[PIPE-1] : '0;

  // Result collection
  assign push_data.count = core_count;
  assign push_data.tag   = core_tag;

  ccf_result_fifo #(
    .DEPTH (RESULT_FIFO_DEPTH),
    .WIDTH ($bits(ccf_result_t))
  ) u_result_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (push_data),
    .pop_i   (pop),
    .dout_o  (pop_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign res_valid = ~fifo_empty;
  assign res_count = pop_data.count;
  assign res_tag   = pop_data.tag;
  assign in_flight = in_flight_q;
  assign idle      = (state_q == IDLE);
  assign err       = err_q;

`ifdef CCF_PERF_COUNTERS_EN
  logic [31:0] perf_offered_q, perf_used_q, perf_starved_q, perf_stalled_q;
  logic        perf_active;

  assign perf_active = (state_q == RUN) | (state_q == DRAIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_offered_q <= '0;
      perf_used_q    <= '0;
      perf_starved_q <= '0;
      perf_stalled_q <= '0;
    end else if (perf_active) begin
      perf_offered_q <= perf_offered_q + 32'(core_request);
      perf_used_q    <= perf_used_q + 32'(accept);
      perf_starved_q <= perf_starved_q + 32'(core_request & ~job_valid);
      perf_stalled_q <= perf_stalled_q + 32'(core_request & job_valid & (credits_q == '0));
    end
  end

  assign perf_offered = perf_offered_q;
  assign perf_used    = perf_used_q;
  assign perf_starved = perf_starved_q;
  assign perf_stalled = perf_stalled_q;
`endif

endmodule
